bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Two-master, single-slave arbiter sharing the word-addressed block RAM bus.
- Typical masters: Cpu on M0, a loader/DMA engine on M1.
- Round-robin arbitration with optional bounded bus locking.
- Tracks the RAM's one-cycle read latency and routes read-valid back to the issuing master.

Parameters:
- ADDR_W, 32, width of word address on all address ports.
- LOCK_MAX, 4, max consecutive grants to one locking master while the other master requests (1..255).

Ports:
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- m0_req  in  1  M0 requests an access this cycle.
- m0_lock  in  1  M0 asks to retain the bus after this access.
- m0_addr  in  ADDR_W  M0 word address.
- m0_data_w  in  32  M0 write data.
- m0_mask_w  in  4  M0 byte write enables.
- m0_write  in  1  1 = write, 0 = read.
- m0_gnt  out  1  M0 access accepted this cycle (combinational).
- m0_rvalid  out  1  M0 read data valid on data_r this cycle.
- m1_*  same set as m0_* for M1.
- data_r  out  32  read data broadcast to both masters (= mem_data_r).
- mem_addr  out  ADDR_W  address to RAM.
- mem_data_r  in  32  RAM read data; valid the cycle after the address.
- mem_data_w  out  32  write data to RAM.
- mem_mask_w  out  4  byte enables to RAM.
- mem_write  out  1  RAM write strobe.

Behaviour:
- State: `last` (1 bit, last granted master), `lock_cnt` (8 bits), `rd_owner` (2 bits, one-hot pending read).
- Reset (reset=0, async):
  - `last` = 1, so M0 wins the first tie.
  - `lock_cnt` = 0, `rd_owner` = 0.
  - m0_rvalid = m1_rvalid = 0.
  - Combinational outputs follow from these state values.
- Grant (combinational, at most one gnt per cycle):
  - Only one master requesting: that master is granted.
  - Both requesting, and `last` master had lock=1 on its previous grant with `lock_cnt` < LOCK_MAX: `last` is granted again.
  - Both requesting otherwise: the master != `last` is granted.
  - No request: no grant.
- Mem outputs:
  - With a grant: mem_addr/data_w/mask_w/write = granted master's signals, and mem_mask_w is forced to 0 on reads.
  - Without a grant: mem_write = 0, mem_mask_w = 0, mem_addr = 0, mem_data_w = 0.
- On each rising edge with a grant:
  - `last` <= granted id.
  - If the same master as the previous grant, the previous grant had lock=1, and the other master requested: `lock_cnt` <= `lock_cnt` + 1, saturating at LOCK_MAX. Otherwise `lock_cnt` <= 0.
  - A grant to a different master always clears `lock_cnt`.
- With no grant: `lock_cnt` <= 0 and `last` holds.
- Lock fairness: once `lock_cnt` = LOCK_MAX, the other requesting master wins the next tie.
- Uncontended lock: a locking master without competition is unlimited; the counter only advances while contended.
- Read return:
  - `rd_owner` <= one-hot of the granted master if the grant was a read, else 0.
  - mN_rvalid = `rd_owner`[N] (registered, exactly 1 cycle after gnt).
  - data_r = mem_data_r.
- Writes produce no rvalid.
- Back-to-back reads from alternating masters every cycle are fully supported, with no bubble.
- Masters hold req and payload stable until gnt. The arbiter never drops an accepted request.
- Reset mid-operation: a pending rvalid is discarded (forced 0) and lock history is cleared.

Test Plan:
- Reset:
  - Stimulus: reset=0 with both req=1, then release reset.
  - Required: m0_rvalid=m1_rvalid=0 during reset. On the first cycle after release, m0_gnt=1 and m1_gnt=0.
- Single-master read:
  - Stimulus: M1 reads addr 0x10 holding 0xDEADBEEF.
  - Required: m1_gnt same cycle; next cycle m1_rvalid=1, data_r=0xDEADBEEF, m0_rvalid=0.
- Round-robin:
  - Stimulus: both masters request reads continuously, lock=0, for 6 cycles.
  - Required: gnt alternates M0,M1,M0,M1,M0,M1; each rvalid follows its gnt by one cycle.
- Lock bound:
  - Stimulus: M0 lock=1 with continuous reads; M1 req=1 continuously; LOCK_MAX=4.
  - Required: M0 receives 5 consecutive grants (initial + 4), then M1 is granted.
- Masked write:
  - Stimulus: M0 writes 0x11223344 mask 4'b0101 to addr 3, then M1 reads addr 3.
  - Required: mem_write pulses one cycle and no rvalid for the write. The read returns bytes 0 and 2 updated, bytes 1 and 3 unchanged.
- Async reset during read:
  - Stimulus: assert reset between a read grant and its return edge.
  - Required: rvalid stays 0; `last` and `lock_cnt` return to reset values immediately.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a single-port word RAM, with bounded bus locking.
// Grants are combinational; read-valid returns to the issuing master one cycle after the grant.
module bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_data_w,
  input  logic [3:0]        m0_mask_w,
  input  logic              m0_write,
  output logic              m0_gnt,
  output logic              m0_rvalid,

  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_data_w,
  input  logic [3:0]        m1_mask_w,
  input  logic              m1_write,
  output logic              m1_gnt,
  output logic              m1_rvalid,

  output logic [31:0]       data_r,

  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data_r,
  output logic [31:0]       mem_data_w,
  output logic [3:0]        mem_mask_w,
  output logic              mem_write
);

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  logic       last;       // id of the most recently granted master
  logic       last_lock;  // lock request that accompanied that grant
  logic [7:0] lock_cnt;
  logic [1:0] rd_owner;

  logic both_req;
  logic hold_bus;
  logic gnt_any;
  logic gnt_id;
  logic gnt_lock;
  logic gnt_write;
  logic other_req;

  assign both_req = m0_req & m1_req;
  // The previous winner keeps the bus on a tie only while its lock budget lasts.
  assign hold_bus = last_lock && (lock_cnt < LOCK_LIM);

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (both_req) begin
      if (hold_bus) begin
        m0_gnt = ~last;
        m1_gnt = last;
      end else begin
        m0_gnt = last;
        m1_gnt = ~last;
      end
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

  assign gnt_any   = m0_gnt | m1_gnt;
  assign gnt_id    = m1_gnt;
  assign gnt_lock  = m1_gnt ? m1_lock  : m0_lock;
  assign gnt_write = m1_gnt ? m1_write : m0_write;
  assign other_req = m1_gnt ? m0_req   : m1_req;

  always_comb begin
    mem_addr   = '0;
    mem_data_w = '0;
    mem_mask_w = '0;
    mem_write  = 1'b0;
    if (m0_gnt) begin
      mem_addr   = m0_addr;
      mem_data_w = m0_data_w;
      mem_mask_w = m0_write ? m0_mask_w : 4'b0000;
      mem_write  = m0_write;
    end else if (m1_gnt) begin
      mem_addr   = m1_addr;
      mem_data_w = m1_data_w;
      mem_mask_w = m1_write ? m1_mask_w : 4'b0000;
      mem_write  = m1_write;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last      <= 1'b1;
      last_lock <= 1'b0;
      lock_cnt  <= 8'd0;
    end else if (gnt_any) begin
      last      <= gnt_id;
      last_lock <= gnt_lock;
      // Only contended re-grants under lock consume the budget.
      if ((gnt_id == last) && last_lock && other_req)
        lock_cnt <= (lock_cnt >= LOCK_LIM) ? LOCK_LIM : lock_cnt + 8'd1;
      else
        lock_cnt <= 8'd0;
    end else begin
      lock_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rd_owner <= 2'b00;
    else if (gnt_any && !gnt_write)
      rd_owner <= {m1_gnt, m0_gnt};
    else
      rd_owner <= 2'b00;
  end

  assign m0_rvalid = rd_owner[0];
  assign m1_rvalid = rd_owner[1];
  assign data_r    = mem_data_r;

endmodule
